// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_sched divided-enable controller.
package clk_div_pkg;

  localparam int CNT_W_DEF       = 16;
  localparam int DEFAULT_DIV_DEF = 3;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/clk_div_sched_if.sv
// Ratio configuration handshake between config logic (master) and clk_div_sched (slave).
interface clk_div_sched_if
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  logic             CFG_VALID;
  logic [CNT_W-1:0] CFG_DIV;
  logic             CFG_READY;
  logic             CFG_ERR;

  modport master (
    output CFG_VALID,
    output CFG_DIV,
    input  CFG_READY,
    input  CFG_ERR
  );

  modport slave (
    input  CFG_VALID,
    input  CFG_DIV,
    output CFG_READY,
    output CFG_ERR
  );

endinterface

// File: rtl/div_phase_cnt.sv
// Phase counter for one divide-by-N period: counts 0..ratio-1 and flags the wrap cycle.
module div_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             en,
  input  logic             load_zero,
  input  logic [CNT_W-1:0] ratio,
  output logic [CNT_W-1:0] phase,
  output logic             wrap
);

  logic [CNT_W-1:0] phase_q;

  // ratio is never zero, so ratio-1 cannot underflow.
  assign wrap  = en && (phase_q == (ratio - CNT_W'(1)));
  assign phase = phase_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_IN) begin
    if (RST || load_zero) begin
      phase_q <= '0;
    end else if (en) begin
      phase_q <= wrap ? '0 : phase_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Programmable divide-by-N tick / clock-enable generator with boundary-aligned ratio changes.
// Optional period counter (PERIOD_CNT / PERIOD_CLR) enabled by defining CLK_DIV_SCHED_PERIOD_CNT_EN.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             CLK_IN,
  input  logic             RST,
  input  logic             EN,
  clk_div_sched_if.slave   cfg,
  output logic             TICK,
  output logic             CLK_EN_OUT,
  output logic [CNT_W-1:0] PHASE_CNT,
  output logic [CNT_W-1:0] CUR_DIV,
  output logic             BUSY
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
  ,
  input  logic             PERIOD_CLR,
  output logic [31:0]      PERIOD_CNT
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, pend_div_q, phase;
  logic [CNT_W:0]   half_div;
  logic             pend_q, err_q, wrap, busy, xfer, accept;

  assign busy   = (state_q != STOP);
  assign xfer   = cfg.CFG_VALID && !pend_q;
  assign accept = xfer && (cfg.CFG_DIV != '0);

  div_phase_cnt #(.CNT_W(CNT_W)) u_phase (
    .CLK_IN    (CLK_IN),
    .RST       (RST),
    .en        (busy),
    .load_zero (!busy),
    .ratio     (cur_div_q),
    .phase     (phase),
    .wrap      (wrap)
  );

  always_ff @(posedge CLK_IN) begin
    if (RST) state_q <= STOP;
    else     state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      STOP:    if (EN) state_d = RUN;
      RUN:     if (!EN) state_d = DRAIN;
      DRAIN:   if (EN) state_d = RUN;
               else if (wrap) state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // Idle: apply immediately. Running: apply at a wrap, else park in the pending register.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      cur_div_q  <= CNT_W'(DEFAULT_DIV);
      pend_div_q <= '0;
      pend_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= xfer && (cfg.CFG_DIV == '0);
      if (!busy) begin
        if (accept) cur_div_q <= cfg.CFG_DIV;
      end else if (wrap) begin
        pend_q <= 1'b0;
        if (accept)      cur_div_q <= cfg.CFG_DIV;
        else if (pend_q) cur_div_q <= pend_div_q;
      end else if (accept) begin
        pend_q     <= 1'b1;
        pend_div_q <= cfg.CFG_DIV;
      end
    end
  end

  // One extra bit keeps (N+1)>>1 exact for N = all-ones.
  assign half_div = ({1'b0, cur_div_q} + (CNT_W + 1)'(1)) >> 1;

  assign TICK          = busy && (phase == '0);
  assign CLK_EN_OUT    = busy && ({1'b0, phase} < half_div);
  assign PHASE_CNT     = phase;
  assign CUR_DIV       = cur_div_q;
  assign BUSY          = busy;
  assign cfg.CFG_READY = !pend_q;
  assign cfg.CFG_ERR   = err_q;

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
  logic [31:0] period_cnt_q, period_base;

  // Clear first, then count, so a clear that coincides with a TICK yields 1.
  assign period_base = (PERIOD_CLR || (state_q == STOP && state_d == RUN)) ? '0 : period_cnt_q;

  always_ff @(posedge CLK_IN) begin
    if (RST)                                 period_cnt_q <= '0;
    else if (TICK && (period_base != '1))    period_cnt_q <= period_base + 32'd1;
    else                                     period_cnt_q <= period_base;
  end

  assign PERIOD_CNT = period_cnt_q;
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: cycle model feeds a scoreboard, plus directed spot checks.
module tb_clk_div_sched;
  import clk_div_pkg::*;

  localparam int CNT_W = 16;
  localparam int DEF   = 3;

  logic             CLK_IN = 1'b0;
  logic             RST    = 1'b1;
  logic             EN     = 1'b0;
  logic             TICK, CLK_EN_OUT, BUSY;
  logic [CNT_W-1:0] PHASE_CNT, CUR_DIV;

  clk_div_sched_if #(.CNT_W(CNT_W)) cfg ();

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
  logic        PERIOD_CLR = 1'b0;
  logic [31:0] PERIOD_CNT;
`endif

  clk_div_sched #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF)) dut (
    .CLK_IN     (CLK_IN),
    .RST        (RST),
    .EN         (EN),
    .cfg        (cfg.slave),
    .TICK       (TICK),
    .CLK_EN_OUT (CLK_EN_OUT),
    .PHASE_CNT  (PHASE_CNT),
    .CUR_DIV    (CUR_DIV),
    .BUSY       (BUSY)
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    ,
    .PERIOD_CLR (PERIOD_CLR),
    .PERIOD_CNT (PERIOD_CNT)
`endif
  );

  always #5 CLK_IN = ~CLK_IN;

  typedef struct {
    logic        tick, clk_en, busy, ready, err;
    logic [31:0] phase, cdiv, pcnt;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model state (0 = stop, 1 = run, 2 = drain).
  int          m_st;
  int unsigned m_ph, m_div, m_pdiv;
  bit          m_pend, m_err;
  logic [31:0] m_pcnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_step();
    bit busy, tick, xfer, dz, acc, wrap, clr;
    int nst;
    busy = (m_st != 0);
    tick = busy && (m_ph == 0);
    if (RST) begin
      m_st = 0; m_ph = 0; m_div = DEF; m_pend = 0; m_pdiv = 0; m_err = 0; m_pcnt = 0;
      return;
    end
    xfer = cfg.CFG_VALID && !m_pend;
    dz   = (cfg.CFG_DIV == 0);
    acc  = xfer && !dz;
    wrap = busy && (m_ph == m_div - 1);
    case (m_st)
      0:       nst = EN ? 1 : 0;
      1:       nst = EN ? 1 : 2;
      default: nst = EN ? 1 : (wrap ? 0 : 2);
    endcase
    clr = (m_st == 0 && nst == 1);
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    clr = clr || PERIOD_CLR;
`endif
    if (clr) m_pcnt = 0;
    if (tick && m_pcnt != 32'hffff_ffff) m_pcnt = m_pcnt + 1;
    if (!busy) begin
      if (acc) m_div = cfg.CFG_DIV;
    end else if (wrap) begin
      if (acc)         m_div = cfg.CFG_DIV;
      else if (m_pend) m_div = m_pdiv;
      m_pend = 0;
    end else if (acc) begin
      m_pend = 1;
      m_pdiv = cfg.CFG_DIV;
    end
    m_ph  = busy ? (wrap ? 0 : m_ph + 1) : 0;
    m_err = xfer && dz;
    m_st  = nst;
  endfunction

  task automatic step();
    exp_t e;
    model_step();
    e.busy   = (m_st != 0);
    e.tick   = e.busy && (m_ph == 0);
    e.clk_en = e.busy && (m_ph < (m_div + 1) / 2);
    e.ready  = !m_pend;
    e.err    = m_err;
    e.phase  = m_ph;
    e.cdiv   = m_div;
    e.pcnt   = m_pcnt;
    sb.push_back(e);
    @(posedge CLK_IN);
    #1;
    cyc++;
    e = sb.pop_front();
    check("tick",      {31'd0, TICK},          {31'd0, e.tick});
    check("clk_en",    {31'd0, CLK_EN_OUT},    {31'd0, e.clk_en});
    check("busy",      {31'd0, BUSY},          {31'd0, e.busy});
    check("cfg_ready", {31'd0, cfg.CFG_READY}, {31'd0, e.ready});
    check("cfg_err",   {31'd0, cfg.CFG_ERR},   {31'd0, e.err});
    check("phase",     {16'd0, PHASE_CNT},     e.phase);
    check("cur_div",   {16'd0, CUR_DIV},       e.cdiv);
`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    check("period_cnt", PERIOD_CNT, e.pcnt);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the model sits at phase p; bounded so a broken DUT cannot hang the run.
  task automatic seek(input int unsigned p);
    for (int i = 0; i < 64 && m_ph != p; i++) step();
    check("seek_phase", {16'd0, PHASE_CNT}, p);
  endtask

  task automatic offer(input logic [CNT_W-1:0] div);
    cfg.CFG_VALID = 1'b1;
    cfg.CFG_DIV   = div;
    step();
    cfg.CFG_VALID = 1'b0;
    cfg.CFG_DIV   = '0;
  endtask

  initial begin
    cfg.CFG_VALID = 1'b0;
    cfg.CFG_DIV   = '0;

    RST = 1'b1;
    run(2);
    RST = 1'b0;
    check("rst_cur_div", {16'd0, CUR_DIV},       DEF);
    check("rst_ready",   {31'd0, cfg.CFG_READY}, 1);
    check("rst_busy",    {31'd0, BUSY},          0);
    check("rst_clk_en",  {31'd0, CLK_EN_OUT},    0);

    // First TICK one cycle after EN, N=3 pattern 1,1,0.
    EN = 1'b1;
    step(); check("first_tick", {31'd0, TICK}, 1); check("n3_en0", {31'd0, CLK_EN_OUT}, 1);
    step(); check("n3_en1", {31'd0, CLK_EN_OUT}, 1); check("n3_tick1", {31'd0, TICK}, 0);
    step(); check("n3_en2", {31'd0, CLK_EN_OUT}, 0);
    step(); check("n3_wrap_tick", {31'd0, TICK}, 1);
    run(6);

    // Ratio offered in the wrap cycle applies at that wrap; READY never drops.
    seek(2);
    offer(16'd4);
    check("wrap_apply_ready", {31'd0, cfg.CFG_READY}, 1);
    check("wrap_apply_div",   {16'd0, CUR_DIV},       4);
    run(9);

    // Zero ratio is rejected with a single ERR pulse.
    seek(1);
    offer(16'd0);
    check("zero_err",  {31'd0, cfg.CFG_ERR}, 1);
    check("zero_div",  {16'd0, CUR_DIV},     4);
    step();
    check("zero_err_once", {31'd0, cfg.CFG_ERR}, 0);
    run(6);

    // Mid-period offer is held pending until the next boundary.
    seek(1);
    offer(16'd5);
    check("pend_ready", {31'd0, cfg.CFG_READY}, 0);
    check("pend_div_hold", {16'd0, CUR_DIV}, 4);
    run(12);

    // Drain: EN drops at phase 1 of N=5 -> three more busy cycles, then STOP.
    seek(1);
    EN = 1'b0;
    run(3);
    check("drain_busy", {31'd0, BUSY}, 1);
    step();
    check("drain_stop", {31'd0, BUSY}, 0);
    check("drain_tick", {31'd0, TICK}, 0);
    run(2);

    // Drain interrupted by EN at phase 3: seamless continuation.
    EN = 1'b1;
    run(3);
    seek(1);
    EN = 1'b0;
    run(2);
    EN = 1'b1;
    step();
    check("resume_phase", {16'd0, PHASE_CNT}, 4);
    step();
    check("resume_tick", {31'd0, TICK}, 1);
    run(4);

    // Reset with a ratio pending restores the default.
    seek(0);
    offer(16'd7);
    check("pend7_ready", {31'd0, cfg.CFG_READY}, 0);
    EN  = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("rst_mid_div",   {16'd0, CUR_DIV},       DEF);
    check("rst_mid_ready", {31'd0, cfg.CFG_READY}, 1);
    check("rst_mid_busy",  {31'd0, BUSY},          0);

    // EN rise together with a handshake in STOP: N=1 governs the first period.
    EN = 1'b1;
    offer(16'd1);
    check("n1_div", {16'd0, CUR_DIV}, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("n1_tick",   {31'd0, TICK},       1);
      check("n1_clk_en", {31'd0, CLK_EN_OUT}, 1);
    end

`ifdef CLK_DIV_SCHED_PERIOD_CNT_EN
    PERIOD_CLR = 1'b1;
    step();
    PERIOD_CLR = 1'b0;
    check("pclr_with_tick", PERIOD_CNT, 1);
    run(3);
`endif

    EN = 1'b0;
    run(3);
    check("end_idle", {31'd0, BUSY}, 0);
    check("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
